sync_fifo_wm: RTL and testbench
===============================

Name: sync_fifo_wm

Overview:
- Parametrised single-clock FIFO; next generation of the UART TX/RX buffer.
- Adds the following over the current buffer:
  - registered read data with a valid strobe;
  - an explicit fill-level output;
  - programmable almost-full and almost-empty thresholds;
  - sticky overflow and underflow error flags;
  - a synchronous flush.
- Sits between the UART shift engines and the bus-side register block. Thresholds are driven from control registers.

Parameters:
- WIDTH, 8, data word width in bits (≥1).
- DEPTH, 16, number of entries; must be a power of two, ≥2.
- LW, $clog2(DEPTH)+1, width of the level and threshold fields; derived, not overridden.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous empty request.
- w_en  in  1  write request.
- w_data  in  WIDTH  write data.
- r_en  in  1  read request.
- r_data  out  WIDTH  read data, registered.
- r_valid  out  1  r_data updated this cycle.
- level  out  LW  current occupancy, 0..DEPTH.
- full  out  1  level==DEPTH.
- empty  out  1  level==0.
- af_thresh  in  LW  almost-full threshold.
- ae_thresh  in  LW  almost-empty threshold.
- almost_full  out  1  (af_thresh!=0) && level>=af_thresh.
- almost_empty  out  1  level<=ae_thresh.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- clr_err  in  1  clears overflow and underflow.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - pointers=0, level=0, r_data=0, r_valid=0, overflow=0, underflow=0;
  - empty=1, full=0, almost_empty=1;
  - almost_full=0, unless af_thresh==0 is not the case and the threshold is met (at level 0 it is 0 for any af_thresh).
  - Reset mid-operation discards all contents and any in-flight read.
- Storage: DEPTH x WIDTH array; contents are not reset.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally DEPTH-1→0.
- level register: the single source of every status flag. All flags are combinational from level and the thresholds; there is no pointer-compare full/empty.
- Write acceptance: wr_acc = w_en && !full && !flush.
  - On wr_acc: mem[wr_ptr] <= w_data; wr_ptr+1.
- Read acceptance: rd_acc = r_en && !empty && !flush.
  - On rd_acc: r_data <= mem[rd_ptr]; rd_ptr+1; r_valid=1 in the next cycle.
  - Otherwise r_valid=0 and r_data holds its value.
- Read latency: one cycle.
- Level update:
  - +1 on wr_acc only;
  - -1 on rd_acc only;
  - unchanged when both or neither occur.
- Simultaneous events:
  - Full with w_en and r_en: the read is accepted, the write is rejected, overflow is set, and level becomes DEPTH-1.
  - Empty with w_en and r_en: the write is accepted, the read is rejected, underflow is set, and level becomes 1.
  - There is no bypass path from write to read.
- Flush:
  - The next cycle gives pointers=0, level=0 and r_valid=0.
  - w_en/r_en are ignored in the flush cycle.
  - Error flags are not affected.
  - rst has priority over flush.
- Error flags:
  - overflow set on w_en && full && !flush.
  - underflow set on r_en && empty && !flush.
  - Cleared by clr_err or rst; a set event wins over clr_err in the same cycle.
- Thresholds:
  - Sampled live; a change takes effect on the flags in the same cycle (combinational).
  - af_thresh=0 disables almost_full.
  - ae_thresh>=DEPTH forces almost_empty=1.
- Arithmetic: all level compares are unsigned LW-bit. Level never exceeds DEPTH and never underflows below 0.

Decomposition:
- Shared package uart_fifo_pkg holds:
  - the log2 helper function;
  - DEPTH/WIDTH defaults for the TX and RX instances;
  - the LW derivation.
- One sub-module, fifo_ram_1r1w: WIDTH x DEPTH array with synchronous write and registered read, enable-gated.
- Pointer, level, flag and error logic stay in sync_fifo_wm.

Test Plan (DEPTH=8, WIDTH=8):
1. Reset, then write 0x01..0x08 on consecutive cycles → level 1..8; full=1 after the 8th write; a 9th write of 0xFF → level stays 8, overflow=1. Read 8 times → r_data 0x01..0x08, each with r_valid one cycle after r_en.
2. Empty FIFO, r_en pulsed → r_valid stays 0, underflow=1; then clr_err asserted → underflow=0. clr_err together with a new r_en on empty → underflow remains 1.
3. af_thresh=6, ae_thresh=2; fill 0→8 → almost_empty=1 for level 0..2, almost_full=1 for level 6..8. Set af_thresh=0 → almost_full=0 immediately.
4. Level 8, w_en and r_en asserted in the same cycle → read accepted, write rejected, level 7, overflow=1. Level 0, both asserted → level 1, underflow=1, r_valid=0.
5. Wrap-around: 20 cycles of interleaved write/read of an incrementing pattern at level 3 → read order is preserved across the pointer wrap, and level stays 3.
6. Level 5, flush with w_en=1 and r_en=1 → next cycle level=0, empty=1, r_valid=0, error flags unchanged. rst asserted mid-stream at level 4 → next cycle level=0, r_data=0, overflow=underflow=0.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// Shared sizing helpers and instance defaults for the UART TX/RX buffers.
// Imported by the FIFO top and its storage array.
package uart_fifo_pkg;

  // Default geometry of the two UART-side instances
  localparam int unsigned TX_WIDTH = 8;
  localparam int unsigned TX_DEPTH = 16;
  localparam int unsigned RX_WIDTH = 8;
  localparam int unsigned RX_DEPTH = 16;

  // Ceiling log2; returns 0 for n <= 1
  function automatic int unsigned log2_ceil(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Level field must represent 0..depth inclusive, hence one extra bit
  function automatic int unsigned level_width(input int unsigned depth);
    return log2_ceil(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram_1r1w.sv
// WIDTH x DEPTH storage with synchronous write and a registered, enable-gated read port.
// Array contents are never reset; only the read register is.
module fifo_ram_1r1w
  import uart_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = TX_WIDTH,
  parameter int unsigned DEPTH = TX_DEPTH,
  localparam int unsigned AW   = log2_ceil(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds its value between accepted reads
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_wm.sv
// Single-clock FIFO with fill level, programmable watermarks, sticky error flags and flush.
// Every status flag is derived from the level register alone.
module sync_fifo_wm
  import uart_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = TX_WIDTH,
  parameter int unsigned DEPTH = TX_DEPTH,
  localparam int unsigned LW   = level_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             w_en,
  input  logic [WIDTH-1:0] w_data,
  input  logic             r_en,
  output logic [WIDTH-1:0] r_data,
  output logic             r_valid,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty,
  input  logic [LW-1:0]    af_thresh,
  input  logic [LW-1:0]    ae_thresh,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int unsigned AW = log2_ceil(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_nx;
  logic [AW-1:0] rd_ptr_q, rd_ptr_nx;
  logic [LW-1:0] level_q, level_nx;
  logic          r_valid_q, r_valid_nx;
  logic          overflow_q, overflow_nx;
  logic          underflow_q, underflow_nx;
  logic          wr_acc, rd_acc;
  logic          ovf_set, udf_set;

  // Status flags: combinational from level and live thresholds
  always_comb begin
    full         = (level_q == LW'(DEPTH));
    empty        = (level_q == '0);
    almost_full  = (af_thresh != '0) && (level_q >= af_thresh);
    almost_empty = (ae_thresh >= LW'(DEPTH)) || (level_q <= ae_thresh);
  end

  assign wr_acc  = w_en && !full  && !flush;
  assign rd_acc  = r_en && !empty && !flush;
  assign ovf_set = w_en && full  && !flush;
  assign udf_set = r_en && empty && !flush;

  // Next-state for pointers, level, read strobe and sticky errors
  always_comb begin
    wr_ptr_nx    = wr_ptr_q;
    rd_ptr_nx    = rd_ptr_q;
    level_nx     = level_q;
    r_valid_nx   = rd_acc;
    overflow_nx  = overflow_q;
    underflow_nx = underflow_q;

    if (flush) begin
      wr_ptr_nx = '0;
      rd_ptr_nx = '0;
      level_nx  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_nx = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr_nx = rd_ptr_q + AW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   level_nx = level_q + LW'(1);
        2'b01:   level_nx = level_q - LW'(1);
        default: level_nx = level_q;
      endcase
    end

    // A set event in the same cycle wins over the clear
    if (clr_err) begin
      overflow_nx  = 1'b0;
      underflow_nx = 1'b0;
    end
    if (ovf_set) begin
      overflow_nx = 1'b1;
    end
    if (udf_set) begin
      underflow_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      r_valid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_nx;
      rd_ptr_q    <= rd_ptr_nx;
      level_q     <= level_nx;
      r_valid_q   <= r_valid_nx;
      overflow_q  <= overflow_nx;
      underflow_q <= underflow_nx;
    end
  end

  fifo_ram_1r1w #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (w_data),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (r_data)
  );

  assign level     = level_q;
  assign r_valid   = r_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_wm.sv
// Directed bench for sync_fifo_wm at DEPTH=8, WIDTH=8 with hand-computed expectations.
module tb_sync_fifo_wm;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = 4;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             w_en;
  logic [WIDTH-1:0] w_data;
  logic             r_en;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [LW-1:0]    level;
  logic             full;
  logic             empty;
  logic [LW-1:0]    af_thresh;
  logic [LW-1:0]    ae_thresh;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;
  logic             clr_err;

  int checks = 0;
  int errors = 0;

  sync_fifo_wm #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .w_en         (w_en),
    .w_data       (w_data),
    .r_en         (r_en),
    .r_data       (r_data),
    .r_valid      (r_valid),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .af_thresh    (af_thresh),
    .ae_thresh    (ae_thresh),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; w_en = 1'b0; w_data = '0; r_en = 1'b0;
    af_thresh = '0; ae_thresh = '0; clr_err = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_rvalid", 32'(r_valid), 0);
    chk("rst_rdata", 32'(r_data), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_udf", 32'(underflow), 0);

    // 1: fill, overflow, drain in order
    for (int i = 1; i <= 8; i++) begin
      w_en = 1'b1; w_data = 8'(i);
      tick();
      chk("t1_fill_level", 32'(level), 32'(i));
    end
    chk("t1_full", 32'(full), 1);
    w_data = 8'hFF;
    tick();
    chk("t1_ovf_level", 32'(level), 8);
    chk("t1_ovf", 32'(overflow), 1);
    w_en = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      r_en = 1'b1;
      tick();
      chk("t1_rvalid", 32'(r_valid), 1);
      chk("t1_rdata", 32'(r_data), 32'(i));
      chk("t1_drain_level", 32'(level), 32'(8 - i));
    end
    r_en = 1'b0;
    tick();
    chk("t1_rvalid_low", 32'(r_valid), 0);
    chk("t1_rdata_hold", 32'(r_data), 8);
    chk("t1_empty", 32'(empty), 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t1_ovf_clr", 32'(overflow), 0);

    // 2: underflow, clear, set-wins-over-clear
    r_en = 1'b1;
    tick();
    chk("t2_rvalid", 32'(r_valid), 0);
    chk("t2_udf", 32'(underflow), 1);
    chk("t2_level", 32'(level), 0);
    r_en = 1'b0; clr_err = 1'b1;
    tick();
    chk("t2_udf_clr", 32'(underflow), 0);
    r_en = 1'b1;
    tick();
    chk("t2_udf_setwins", 32'(underflow), 1);
    r_en = 1'b0;
    tick();
    clr_err = 1'b0;
    chk("t2_udf_final", 32'(underflow), 0);

    // 3: watermarks
    af_thresh = 4'd6; ae_thresh = 4'd2;
    #1;
    chk("t3_ae0", 32'(almost_empty), 1);
    chk("t3_af0", 32'(almost_full), 0);
    for (int i = 1; i <= 8; i++) begin
      w_en = 1'b1; w_data = 8'(8'h10 + i);
      tick();
      chk("t3_ae", 32'(almost_empty), (i <= 2) ? 1 : 0);
      chk("t3_af", 32'(almost_full), (i >= 6) ? 1 : 0);
    end
    w_en = 1'b0;
    af_thresh = '0;
    #1;
    chk("t3_af_disabled", 32'(almost_full), 0);
    ae_thresh = 4'd8;
    #1;
    chk("t3_ae_forced", 32'(almost_empty), 1);
    ae_thresh = 4'd2;

    // 4: simultaneous read/write at full and at empty
    w_en = 1'b1; r_en = 1'b1; w_data = 8'hAA;
    tick();
    chk("t4_full_level", 32'(level), 7);
    chk("t4_full_ovf", 32'(overflow), 1);
    chk("t4_full_rvalid", 32'(r_valid), 1);
    chk("t4_full_rdata", 32'(r_data), 8'h11);
    w_en = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk("t4_drain_rdata", 32'(r_data), 32'(8'h10 + i));
    end
    r_en = 1'b0; clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t4_empty", 32'(empty), 1);
    w_en = 1'b1; r_en = 1'b1; w_data = 8'h55;
    tick();
    chk("t4_empty_level", 32'(level), 1);
    chk("t4_empty_udf", 32'(underflow), 1);
    chk("t4_empty_rvalid", 32'(r_valid), 0);
    chk("t4_empty_ovf", 32'(overflow), 0);
    w_en = 1'b0;
    tick();
    chk("t4_rd55", 32'(r_data), 8'h55);
    chk("t4_rd55_level", 32'(level), 0);
    r_en = 1'b0; clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // 5: steady level 3 across pointer wrap
    for (int i = 0; i < 3; i++) begin
      w_en = 1'b1; w_data = 8'(8'h20 + i);
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      w_en = 1'b1; r_en = 1'b1; w_data = 8'(8'h23 + k);
      tick();
      chk("t5_rdata", 32'(r_data), 32'(8'h20 + k));
      chk("t5_level", 32'(level), 3);
    end
    w_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_tail", 32'(r_data), 32'(8'h34 + k));
    end
    r_en = 1'b0;
    tick();
    chk("t5_empty", 32'(empty), 1);

    // 6: flush keeps error flags; reset mid-stream clears everything
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    chk("t6_udf_set", 32'(underflow), 1);
    for (int i = 0; i < 5; i++) begin
      w_en = 1'b1; w_data = 8'(8'h40 + i);
      tick();
    end
    chk("t6_level5", 32'(level), 5);
    flush = 1'b1; w_en = 1'b1; r_en = 1'b1;
    tick();
    flush = 1'b0; w_en = 1'b0; r_en = 1'b0;
    chk("t6_flush_level", 32'(level), 0);
    chk("t6_flush_empty", 32'(empty), 1);
    chk("t6_flush_rvalid", 32'(r_valid), 0);
    chk("t6_flush_udf", 32'(underflow), 1);
    chk("t6_flush_ovf", 32'(overflow), 0);
    for (int i = 0; i < 5; i++) begin
      w_en = 1'b1; w_data = 8'(8'h60 + i);
      tick();
    end
    w_en = 1'b0; r_en = 1'b1;
    tick();
    r_en = 1'b0;
    chk("t6_post_flush_rd", 32'(r_data), 8'h60);
    chk("t6_level4", 32'(level), 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_level", 32'(level), 0);
    chk("t6_rst_rdata", 32'(r_data), 0);
    chk("t6_rst_ovf", 32'(overflow), 0);
    chk("t6_rst_udf", 32'(underflow), 0);
    chk("t6_rst_rvalid", 32'(r_valid), 0);
    w_en = 1'b1; w_data = 8'h77;
    tick();
    w_en = 1'b0; r_en = 1'b1;
    tick();
    r_en = 1'b0;
    chk("t6_after_rst_rd", 32'(r_data), 8'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
